// File: rtl/lc3b_types.sv
// ============================================================================
// lc3b_types -- shared cache line type and L2 controller state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

  localparam int ADDR_W   = 16;
  localparam int OFFSET_W = 4;

  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    L2_IDLE      = 2'd0,
    L2_COMPARE   = 2'd1,
    L2_WRITEBACK = 2'd2,
    L2_ALLOCATE  = 2'd3
  } l2_state_e;

endpackage

`default_nettype wire

// File: rtl/l2_cache_nway_plru.sv
// ============================================================================
// l2_plru -- tree pseudo-LRU: update toward an accessed way, pick a victim
// Revision: 1.0
// ============================================================================
`default_nettype none

module l2_plru #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-2:0]         tree_in,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [WAYS-2:0]         tree_out,
  output logic [$clog2(WAYS)-1:0] victim_way
);

  localparam int LEVELS = $clog2(WAYS);

  // Heap-ordered nodes; a node bit of 1 means the victim lies in the right subtree.
  always_comb begin
    int  node;
    int  vnode;
    logic b;
    logic d;
    tree_out = tree_in;
    node     = 0;
    vnode    = 0;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      b = access_way[LEVELS-1-lvl];
      d = 1'b0;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == node) tree_out[n] = ~b;
        if (n == vnode) d = tree_in[n];
      end
      node  = 2*node + (b ? 2 : 1);
      vnode = 2*vnode + (d ? 2 : 1);
    end
    victim_way = ($clog2(WAYS))'(vnode - (WAYS-1));
  end

endmodule

`default_nettype wire

// File: rtl/l2_cache_nway.sv
// ============================================================================
// l2_cache_nway -- N-way write-back L2 cache with pseudo-LRU replacement.
// Build option: define L2_PERF_CTR_EN to build the hit/miss counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l2_cache_nway
  import lc3b_types::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
  localparam int WAY_W   = $clog2(WAYS);

  l2_state_e          state;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [2:0]         req_word;
  logic [15:0]        req_wdata;
  logic               req_write;
  logic [WAY_W-1:0]   victim;

  logic [WAYS-1:0]    valid_arr [SETS];
  logic [WAYS-1:0]    dirty_arr [SETS];
  logic [WAYS-2:0]    plru_arr  [SETS];
  logic [TAG_W-1:0]   tag_arr   [WAYS][SETS];
  lc3b_cacheline      data_arr  [WAYS][SETS];

  logic               hit;
  logic               has_invalid;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   inv_way;
  logic [WAY_W-1:0]   plru_victim;
  logic [WAY_W-1:0]   miss_way;
  logic [WAYS-2:0]    plru_next;
  lc3b_cacheline      hit_line;
  logic               unused_addr_bit;

  assign unused_addr_bit = mem_address[0];

  // Descending scan so the lowest-index matching/invalid way wins.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_arr[req_index][w] && (tag_arr[w][req_index] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_arr[req_index][w]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
    end
    miss_way = has_invalid ? inv_way : plru_victim;
  end

  l2_plru #(.WAYS(WAYS)) u_plru (
    .tree_in    (plru_arr[req_index]),
    .access_way (hit_way),
    .tree_out   (plru_next),
    .victim_way (plru_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= L2_IDLE;
      req_tag   <= '0;
      req_index <= '0;
      req_word  <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
      victim    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        L2_IDLE: begin
          if (mem_read || mem_write) begin
            req_tag   <= mem_address[15 -: TAG_W];
            req_index <= mem_address[OFFSET_W +: INDEX_W];
            req_word  <= mem_address[3:1];
            req_wdata <= mem_wdata;
            req_write <= mem_write;
            state     <= L2_COMPARE;
          end
        end
        L2_COMPARE: begin
          if (hit) begin
            if (req_write) dirty_arr[req_index][hit_way] <= 1'b1;
            plru_arr[req_index] <= plru_next;
            state               <= L2_IDLE;
          end else begin
            victim <= miss_way;
            state  <= dirty_arr[req_index][miss_way] ? L2_WRITEBACK : L2_ALLOCATE;
          end
        end
        L2_WRITEBACK: begin
          if (pmem_resp) state <= L2_ALLOCATE;
        end
        L2_ALLOCATE: begin
          if (pmem_resp) begin
            valid_arr[req_index][victim] <= 1'b1;
            dirty_arr[req_index][victim] <= 1'b0;
            state                        <= L2_COMPARE;
          end
        end
        default: state <= L2_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (state == L2_ALLOCATE && pmem_resp) begin
      data_arr[victim][req_index] <= pmem_rdata;
      tag_arr[victim][req_index]  <= req_tag;
    end else if (state == L2_COMPARE && hit && req_write) begin
      data_arr[hit_way][req_index][{req_word, 4'h0} +: 16] <= req_wdata;
    end
  end

  assign hit_line     = data_arr[hit_way][req_index];
  assign mem_resp     = (state == L2_COMPARE) && hit;
  assign mem_rdata    = (mem_resp && !req_write) ? hit_line[{req_word, 4'h0} +: 16] : 16'h0000;
  assign pmem_read    = (state == L2_ALLOCATE);
  assign pmem_write   = (state == L2_WRITEBACK);
  assign pmem_address = pmem_write ? {tag_arr[victim][req_index], req_index, 4'h0} :
                        pmem_read  ? {req_tag, req_index, 4'h0} : 16'h0000;
  assign pmem_wdata   = pmem_write ? data_arr[victim][req_index] : '0;

`ifdef L2_PERF_CTR_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;
  logic        refill;

  // refill marks the re-entry into COMPARE after a line fill, which is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      refill <= 1'b0;
    end else begin
      if (state == L2_ALLOCATE && pmem_resp) refill <= 1'b1;
      else if (state == L2_IDLE)             refill <= 1'b0;
      if (state == L2_COMPARE && !refill) begin
        if (hit) begin
          if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
        end else begin
          if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_cache_nway.sv
// ============================================================================
// tb_l2_cache_nway -- scoreboard bench for l2_cache_nway (WAYS=2, SETS=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_l2_cache_nway;

`ifdef L2_PERF_CTR_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [127:0] LINE1 = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                    16'h3333, 16'h2222, 16'hBEEF, 16'h0000};
  localparam logic [127:0] LINE1_WB = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                       16'h3333, 16'h2222, 16'hBEEF, 16'hCAFE};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0]  mem_address = '0, mem_wdata = '0;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_resp = 1'b0;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [15:0]  hit_count, miss_count;

  l2_cache_nway #(.WAYS(2), .SETS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [15:0] data; } sb_t;
  typedef struct { bit we; logic [15:0] addr; logic [127:0] data; } plog_t;

  sb_t           sb[$];
  plog_t         plog[$];
  logic [127:0]  mem [4096];
  int            checks = 0;
  int            errors = 0;
  bit            mem_en = 1'b1;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT completes a request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pmem_read && pmem_write) begin
        checks++; errors++;
        $display("FAIL pmem_exclusive actual=both required=one");
      end
      if (mem_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=1 required=0");
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (!e.wr) chk("rdata", {112'h0, mem_rdata}, {112'h0, e.data});
        end
      end
    end
  end

  // Physical memory model: answers each transfer three cycles after it appears.
  initial begin
    int busy;
    busy = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_en) begin
        pmem_resp = 1'b0;
        if (rst_n && (pmem_read || pmem_write)) begin
          busy++;
          if (busy == 3) begin
            busy = 0;
            if (pmem_write) mem[pmem_address[15:4]] = pmem_wdata;
            else            pmem_rdata = mem[pmem_address[15:4]];
            plog.push_back('{we: pmem_write, addr: pmem_address, data: pmem_wdata});
            pmem_resp = 1'b1;
          end
        end else busy = 0;
      end else busy = 0;
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp, output int lat);
    sb.push_back('{wr: wr, data: exp});
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!mem_resp && lat < 300);
    if (!mem_resp) begin
      checks++; errors++;
      $display("FAIL req_timeout addr=%0h actual=none required=mem_resp", a);
      void'(sb.pop_back());
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic chk_log1(input string n, input bit we, input logic [15:0] a);
    chk({n, "_count"}, 128'(plog.size()), 128'd1);
    if (plog.size() >= 1) begin
      chk({n, "_we"}, {127'h0, plog[0].we}, {127'h0, we});
      chk({n, "_addr"}, {112'h0, plog[0].addr}, {112'h0, a});
    end
    plog.delete();
  endtask

  task automatic chk_ctr(input string n, input int h, input int m);
    chk({n, "_hit"},  {112'h0, hit_count},  PERF ? 128'(h) : 128'd0);
    chk({n, "_miss"}, {112'h0, miss_count}, PERF ? 128'(m) : 128'd0);
  endtask

  initial begin
    int lat;
    for (int l = 0; l < 4096; l++)
      for (int w = 0; w < 8; w++) begin
        logic [3:0]  wv;
        logic [11:0] lv;
        wv = 4'(w); lv = 12'(l);
        mem[l][w*16 +: 16] = {wv, lv};
      end
    mem[1] = LINE1;

    repeat (3) @(negedge clk);
    chk("rst_mem_resp", {127'h0, mem_resp}, 128'd0);
    chk("rst_pmem_read", {127'h0, pmem_read}, 128'd0);
    chk("rst_pmem_write", {127'h0, pmem_write}, 128'd0);
    chk("rst_pmem_addr", {112'h0, pmem_address}, 128'd0);
    chk_ctr("rst", 0, 0);
    rst_n = 1'b1;

    do_req(1, 0, 16'h0010, 16'h0, 16'h0000, lat);   // cold miss
    chk("cold_slow", {127'h0, lat > 2}, 128'd1);
    chk_log1("cold", 1'b0, 16'h0010);
    chk_ctr("cold", 0, 1);

    do_req(1, 0, 16'h0012, 16'h0, 16'hBEEF, lat);
    chk("hit_lat", 128'(lat), 128'd2);
    chk("hit_nopmem", 128'(plog.size()), 128'd0);
    chk_ctr("hit", 1, 1);

    do_req(0, 1, 16'h0010, 16'hCAFE, 16'h0, lat);
    chk("whit_lat", 128'(lat), 128'd2);
    chk("whit_nopmem", 128'(plog.size()), 128'd0);
    do_req(1, 0, 16'h0010, 16'h0, 16'hCAFE, lat);
    chk_ctr("whit", 3, 1);

    do_req(1, 0, 16'h0090, 16'h0, 16'h0009, lat);
    chk_log1("fill90", 1'b0, 16'h0090);
    do_req(0, 1, 16'h0010, 16'hCAFE, 16'h0, lat);
    do_req(1, 0, 16'h0110, 16'h0, 16'h0011, lat);   // evicts clean 0x0090
    chk_log1("ev90", 1'b0, 16'h0110);
    chk_ctr("ev90", 4, 3);

    do_req(1, 0, 16'h0192, 16'h0, 16'h1019, lat);   // evicts dirty 0x0010
    chk("wb_count", 128'(plog.size()), 128'd2);
    if (plog.size() == 2) begin
      chk("wb_we", {127'h0, plog[0].we}, 128'd1);
      chk("wb_addr", {112'h0, plog[0].addr}, 128'h0010);
      chk("wb_data", plog[0].data, LINE1_WB);
      chk("wb_rd_we", {127'h0, plog[1].we}, 128'd0);
      chk("wb_rd_addr", {112'h0, plog[1].addr}, 128'h0190);
    end
    plog.delete();

    do_req(1, 0, 16'h0010, 16'h0, 16'hCAFE, lat);   // refetch written-back line
    chk_log1("refetch", 1'b0, 16'h0010);

    do_req(1, 1, 16'h0020, 16'h1234, 16'h0, lat);   // both strobes: write
    chk_log1("both", 1'b0, 16'h0020);
    do_req(1, 0, 16'h0020, 16'h0, 16'h1234, lat);
    chk("both_rb_lat", 128'(lat), 128'd2);
    chk_ctr("both", 5, 6);

    // Reset in the middle of a fill
    mem_en = 1'b0;
    pmem_resp = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 16'h0030;
    lat = 0;
    while (!pmem_read && lat < 20) begin @(negedge clk); lat++; end
    chk("pre_rst_pread", {127'h0, pmem_read}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pread_now", {127'h0, pmem_read}, 128'd0);
    chk("rst_paddr_now", {112'h0, pmem_address}, 128'd0);
    chk_ctr("midrst", 0, 0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pmem_resp = 1'b1; pmem_rdata = '1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("stale_pread", {127'h0, pmem_read}, 128'd0);
    chk("stale_resp", {127'h0, mem_resp}, 128'd0);
    mem_en = 1'b1;
    plog.delete();

    do_req(1, 0, 16'h0030, 16'h0, 16'h0003, lat);
    chk("post_rst_slow", {127'h0, lat > 2}, 128'd1);
    chk_log1("post_rst", 1'b0, 16'h0030);
    chk_ctr("post_rst", 0, 1);

    repeat (2) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
